// File: rtl/madd_msub_pkg.sv
// rtl/madd_msub_pkg.sv - shared constants and FSM encoding for the MADD_MSUB sequencer
package madd_msub_pkg;

    localparam int DEF_DW = 16;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LDA,
        ST_LDB,
        ST_LDP,
        ST_START,
        ST_WAIT,
        ST_READ,
        ST_DONE
    } state_e;

endpackage

// File: rtl/madd_msub_sched_arb.sv
// rtl/madd_msub_sched_arb.sv - 2-way round-robin arbiter
// Ports: clk, rst (async active-low), req0/req1 (qualified requests),
//        advance (a grant is being taken this cycle), gnt0/gnt1 (combinational grants).
// Pointer 0 favours req0; after each grant it points at the other requester.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic gnt0,
    output logic gnt1
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt0  = req0 & (~req1 | ~ptr_q);
        gnt1  = req1 & (~req0 |  ptr_q);
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = gnt0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/madd_msub_sched.sv
// rtl/madd_msub_sched.sv - two-requester sequencer in front of the MADD_MSUB unit
// Optional feature: define MADD_SCHED_TIMEOUT_EN for a WAIT watchdog (parameter TMO).
// Ports: clk, rst (async active-low); req/op/a/b/p per requester; gnt0/gnt1 grant pulses;
//        done/rsp_id/res/res_flag/err result return; datain/loada/loadb/loadp/madd_en/
//        msub_en/outs0/outs1 drive the unit; regs0out/regs1out/result_rdy/result_flag
//        come back from it. NWORDS must be at least 2.
module madd_msub_sched
    import madd_msub_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int NWORDS = 4
`ifdef MADD_SCHED_TIMEOUT_EN
    ,
    parameter int TMO    = 255
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0,
    input  logic                   req1,
    input  logic                   op0,
    input  logic                   op1,
    input  logic [DW*NWORDS-1:0]   a0,
    input  logic [DW*NWORDS-1:0]   b0,
    input  logic [DW*NWORDS-1:0]   p0,
    input  logic [DW*NWORDS-1:0]   a1,
    input  logic [DW*NWORDS-1:0]   b1,
    input  logic [DW*NWORDS-1:0]   p1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic                   done,
    output logic                   rsp_id,
    output logic [DW*NWORDS-1:0]   res,
    output logic                   res_flag,
    output logic                   err,
    output logic [DW-1:0]          datain,
    output logic                   loada,
    output logic                   loadb,
    output logic                   loadp,
    output logic                   madd_en,
    output logic                   msub_en,
    output logic                   outs0,
    output logic                   outs1,
    input  logic [DW-1:0]          regs0out,
    input  logic [DW-1:0]          regs1out,
    input  logic                   result_rdy,
    input  logic                   result_flag
);

    localparam int W  = DW * NWORDS;
    localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            op_q, op_d;
    logic            id_q, id_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, p_q, p_d;
    logic [W-1:0]    acc_q, acc_d;
    logic            flag_q, flag_d;
    logic [W-1:0]    res_q, res_d;
    logic            res_flag_q, res_flag_d;
    logic            rsp_id_q, rsp_id_d;
    // Low for the first cycle after reset release so no grant can appear while rst is low.
    logic            armed_q, armed_d;
    logic            cnt_last;
    logic [DW-1:0]   rd_word;
    logic            idle;

`ifdef MADD_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            err_q, err_d;
`endif

    assign idle = (state_q == ST_IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0 & idle & armed_q),
        .req1    (req1 & idle & armed_q),
        .advance (gnt0 | gnt1),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        p_d        = p_q;
        acc_d      = acc_q;
        flag_d     = flag_q;
        res_d      = res_q;
        res_flag_d = res_flag_q;
        rsp_id_d   = rsp_id_q;
        armed_d    = 1'b1;
`ifdef MADD_SCHED_TIMEOUT_EN
        tmo_d      = tmo_q;
        err_d      = err_q;
`endif
        cnt_last   = (cnt_q == CW'(NWORDS - 1));
        rd_word    = flag_q ? regs1out : regs0out;

        case (state_q)
            ST_IDLE: begin
                if (gnt0 | gnt1) begin
                    state_d = ST_LDA;
                    cnt_d   = '0;
                    id_d    = gnt1;
                    op_d    = gnt1 ? op1 : op0;
                    a_d     = gnt1 ? a1  : a0;
                    b_d     = gnt1 ? b1  : b0;
                    p_d     = gnt1 ? p1  : p0;
                end
            end
            // Operands are shifted right so the current word is always in the low DW bits.
            ST_LDA: begin
                a_d   = a_q >> DW;
                cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) state_d = ST_LDB;
            end
            ST_LDB: begin
                b_d   = b_q >> DW;
                cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) state_d = ST_LDP;
            end
            ST_LDP: begin
                p_d   = p_q >> DW;
                cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT;
`ifdef MADD_SCHED_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (result_rdy) begin
                    flag_d  = result_flag;
                    cnt_d   = '0;
                    state_d = ST_READ;
`ifdef MADD_SCHED_TIMEOUT_EN
                end else if (tmo_q == TW'(TMO - 1)) begin
                    res_d      = '0;
                    res_flag_d = 1'b0;
                    rsp_id_d   = id_q;
                    err_d      = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            // Words arrive LSW first and enter at the top, so after NWORDS shifts word 0 is at the bottom.
            // Results are published only on entry to DONE so res holds between jobs.
            ST_READ: begin
                acc_d = {rd_word, acc_q[W-1:DW]};
                cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) begin
                    res_d      = acc_d;
                    res_flag_d = flag_q;
                    rsp_id_d   = id_q;
`ifdef MADD_SCHED_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            id_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            acc_q      <= '0;
            flag_q     <= 1'b0;
            res_q      <= '0;
            res_flag_q <= 1'b0;
            rsp_id_q   <= 1'b0;
            armed_q    <= 1'b0;
`ifdef MADD_SCHED_TIMEOUT_EN
            tmo_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            p_q        <= p_d;
            acc_q      <= acc_d;
            flag_q     <= flag_d;
            res_q      <= res_d;
            res_flag_q <= res_flag_d;
            rsp_id_q   <= rsp_id_d;
            armed_q    <= armed_d;
`ifdef MADD_SCHED_TIMEOUT_EN
            tmo_q      <= tmo_d;
            err_q      <= err_d;
`endif
        end
    end

    assign loada    = (state_q == ST_LDA);
    assign loadb    = (state_q == ST_LDB);
    assign loadp    = (state_q == ST_LDP);
    assign datain   = loada ? a_q[DW-1:0] :
                      loadb ? b_q[DW-1:0] :
                      loadp ? p_q[DW-1:0] : '0;
    assign madd_en  = (state_q == ST_START) && (op_q == OP_ADD);
    assign msub_en  = (state_q == ST_START) && (op_q == OP_SUB);
    assign outs0    = (state_q == ST_READ) && !flag_q;
    assign outs1    = (state_q == ST_READ) &&  flag_q;
    assign done     = (state_q == ST_DONE);
    assign res      = res_q;
    assign res_flag = res_flag_q;
    assign rsp_id   = rsp_id_q;
`ifdef MADD_SCHED_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_madd_msub_sched.sv
// tb/tb_madd_msub_sched.sv - self-checking bench for madd_msub_sched
module tb_madd_msub_sched;

    localparam int DW = 16;
    localparam int NW = 4;
    localparam int W  = DW * NW;
`ifdef MADD_SCHED_TIMEOUT_EN
    localparam int TMO = 20;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, p0 = '0, a1 = '0, b1 = '0, p1 = '0;
    logic gnt0, gnt1, done, rsp_id, res_flag, err;
    logic [W-1:0] res;
    logic [DW-1:0] datain, regs0out, regs1out;
    logic loada, loadb, loadp, madd_en, msub_en, outs0, outs1;
    logic result_rdy = 1'b0;
    logic result_flag;

    int n_vec = 0;
    int n_mis = 0;

    madd_msub_sched #(
        .DW(DW), .NWORDS(NW)
`ifdef MADD_SCHED_TIMEOUT_EN
        , .TMO(TMO)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .p0(p0), .a1(a1), .b1(b1), .p1(p1),
        .gnt0(gnt0), .gnt1(gnt1), .done(done), .rsp_id(rsp_id),
        .res(res), .res_flag(res_flag), .err(err),
        .datain(datain), .loada(loada), .loadb(loadb), .loadp(loadp),
        .madd_en(madd_en), .msub_en(msub_en), .outs0(outs0), .outs1(outs1),
        .regs0out(regs0out), .regs1out(regs1out),
        .result_rdy(result_rdy), .result_flag(result_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Behavioural MADD_MSUB unit: loads LSW first, raises result_rdy 5 cycles after enable.
    logic [W-1:0] ua = '0, ub = '0, up = '0, u_raw = '0, u_cor = '0;
    logic [W:0]   u_s;
    logic         u_flag = 1'b0;
    logic         u_mute = 1'b0;
    int           u_cnt = 0;
    logic [1:0]   u_idx = '0;
    logic [W-1:0] sh0, sh1;

    assign result_flag = u_flag;
    always_comb begin
        sh0 = u_raw >> (int'(u_idx) * DW);
        sh1 = u_cor >> (int'(u_idx) * DW);
        regs0out = sh0[DW-1:0];
        regs1out = sh1[DW-1:0];
    end

    always @(posedge clk) begin
        if (loada) ua <= {datain, ua[W-1:DW]};
        if (loadb) ub <= {datain, ub[W-1:DW]};
        if (loadp) up <= {datain, up[W-1:DW]};
        if (madd_en) begin
            u_s    = {1'b0, ua} + {1'b0, ub};
            u_flag <= (u_s >= {1'b0, up});
            u_raw  <= u_s[W-1:0];
            u_cor  <= u_s[W-1:0] - up;
        end else if (msub_en) begin
            u_flag <= (ua < ub);
            u_raw  <= ua - ub;
            u_cor  <= ua - ub + up;
        end
        if (madd_en || msub_en) begin
            u_cnt      <= 5;
            result_rdy <= 1'b0;
            u_idx      <= '0;
        end else begin
            if (u_cnt > 0) begin
                u_cnt      <= u_cnt - 1;
                result_rdy <= (u_cnt == 1) && !u_mute;
            end
            if (outs0 || outs1) u_idx <= u_idx + 2'd1;
        end
    end

    // Reference model of the scheduler: a job timeline indexed by cycles since grant.
    logic         m_busy = 1'b0, m_ptr = 1'b0, m_armed = 1'b0;
    int           m_t = 0, m_rd = 0, m_done_t = 0;
    logic         m_to = 1'b0, m_op = 1'b0, m_id = 1'b0, m_flag = 1'b0;
    logic [W-1:0] m_a, m_b, m_p, m_val;
    logic [W:0]   m_s;
    logic [W-1:0] h_res = '0;
    logic         h_flag = 1'b0, h_id = 1'b0, h_err = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0; m_ptr = 1'b0; m_armed = 1'b0;
            h_res = '0; h_flag = 1'b0; h_id = 1'b0; h_err = 1'b0;
        end else begin
            if (!m_busy) begin
                if (m_armed && (req0 || req1)) begin
                    m_id  = (req0 && (!req1 || !m_ptr)) ? 1'b0 : 1'b1;
                    m_ptr = !m_id;
                    m_op  = m_id ? op1 : op0;
                    m_a   = m_id ? a1 : a0;
                    m_b   = m_id ? b1 : b0;
                    m_p   = m_id ? p1 : p0;
                    if (!m_op) begin
                        m_s    = {1'b0, m_a} + {1'b0, m_b};
                        m_flag = (m_s >= {1'b0, m_p});
                        m_val  = m_flag ? m_s[W-1:0] - m_p : m_s[W-1:0];
                    end else begin
                        m_flag = (m_a < m_b);
                        m_val  = m_flag ? m_a - m_b + m_p : m_a - m_b;
                    end
                    m_busy = 1'b1; m_t = 1; m_rd = 0; m_done_t = 0; m_to = 1'b0;
                end
            end else begin
                if (m_t >= 3 * NW + 2 && m_done_t == 0) begin
                    if (result_rdy) begin
                        m_rd = m_t + 1;
                        m_done_t = m_t + NW + 1;
`ifdef MADD_SCHED_TIMEOUT_EN
                    end else if (m_t == 3 * NW + 1 + TMO) begin
                        m_to = 1'b1;
                        m_done_t = m_t + 1;
`endif
                    end
                end
                if (m_done_t != 0 && m_t + 1 == m_done_t) begin
                    h_id   = m_id;
                    h_res  = m_to ? '0 : m_val;
                    h_flag = m_to ? 1'b0 : m_flag;
                    h_err  = m_to;
                end
                if (m_done_t != 0 && m_t == m_done_t) m_busy = 1'b0;
                m_t++;
            end
            m_armed = 1'b1;
        end
    end

    int n_madd = 0, n_msub = 0, n_o0 = 0, n_o1 = 0, n_g1 = 0, n_done = 0, la_n = 0;
    logic [DW-1:0] la_log [0:3];

    always @(negedge clk) begin
        logic e_g0, e_g1, e_la, e_lb, e_lp, e_madd, e_msub, e_o0, e_o1, e_done;
        logic [DW-1:0] e_din;
        logic [W-1:0]  sh;
        e_g0 = 0; e_g1 = 0; e_la = 0; e_lb = 0; e_lp = 0; e_madd = 0; e_msub = 0;
        e_o0 = 0; e_o1 = 0; e_done = 0; e_din = '0; sh = '0;
        if (rst) begin
            if (!m_busy) begin
                if (m_armed) begin
                    e_g0 = req0 && (!req1 || !m_ptr);
                    e_g1 = req1 && (!req0 ||  m_ptr);
                end
            end else begin
                if (m_t >= 1 && m_t <= NW) begin
                    e_la = 1; sh = m_a >> ((m_t - 1) * DW); e_din = sh[DW-1:0];
                end else if (m_t > NW && m_t <= 2 * NW) begin
                    e_lb = 1; sh = m_b >> ((m_t - NW - 1) * DW); e_din = sh[DW-1:0];
                end else if (m_t > 2 * NW && m_t <= 3 * NW) begin
                    e_lp = 1; sh = m_p >> ((m_t - 2 * NW - 1) * DW); e_din = sh[DW-1:0];
                end
                e_madd = (m_t == 3 * NW + 1) && !m_op;
                e_msub = (m_t == 3 * NW + 1) &&  m_op;
                if (m_rd != 0 && m_t >= m_rd && m_t < m_rd + NW) begin
                    e_o0 = !m_flag; e_o1 = m_flag;
                end
                e_done = (m_done_t != 0) && (m_t == m_done_t);
            end
        end
        chk("gnt0", gnt0, e_g0);
        chk("gnt1", gnt1, e_g1);
        chk("loada", loada, e_la);
        chk("loadb", loadb, e_lb);
        chk("loadp", loadp, e_lp);
        chk("datain", datain, e_din);
        chk("madd_en", madd_en, e_madd);
        chk("msub_en", msub_en, e_msub);
        chk("outs0", outs0, e_o0);
        chk("outs1", outs1, e_o1);
        chk("done", done, e_done);
        chk("rsp_id", rsp_id, h_id);
        chk("res", res, h_res);
        chk("res_flag", res_flag, h_flag);
        chk("err", err, h_err);
        if (madd_en) n_madd++;
        if (msub_en) n_msub++;
        if (outs0) n_o0++;
        if (outs1) n_o1++;
        if (gnt1) n_g1++;
        if (done) n_done++;
        if (loada && la_n < 4) begin
            la_log[la_n] = datain;
            la_n++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic grant_wait(input int id, input int budget);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if ((id == 0 && gnt0) || (id == 1 && gnt1)) begin
                got = 1;
                step();
                if (id == 0) req0 = 1'b0; else req1 = 1'b0;
                break;
            end
            step();
        end
        chk($sformatf("grant%0d_seen", id), got, 1'b1);
    endtask

    task automatic wait_done(input int budget, output int n);
        bit got = 0;
        n = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                got = 1;
                n = i;
                break;
            end
            step();
        end
        chk("done_seen", got, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        int n, s_madd, s_msub, s_o0, s_o1, s_g1, s_done;
        step();
        #1;
        chk("reset_gnt0", gnt0, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_res", res, 64'h0);
        rst = 1'b1;
        step();

        // 1: single add from requester 0
        s_madd = n_madd; s_msub = n_msub;
        op0 = 1'b0; a0 = 64'h0003_0000_0000_0005; b0 = 64'h9; p0 = 64'h0004_0000_0000_0011;
        req0 = 1'b1;
        grant_wait(0, 10);
        wait_done(100, n);
        chk("t1_latency", n, 23);
        chk("t1_res", res, 64'h0003_0000_0000_000E);
        chk("t1_flag", res_flag, 1'b0);
        chk("t1_id", rsp_id, 1'b0);
        chk("t1_madd", n_madd - s_madd, 1);
        chk("t1_msub", n_msub - s_msub, 0);
        chk("t1_w0", la_log[0], 16'h0005);
        chk("t1_w1", la_log[1], 16'h0000);
        chk("t1_w2", la_log[2], 16'h0000);
        chk("t1_w3", la_log[3], 16'h0003);
        step();

        // 2: both requesting, round-robin 0,1,0,1 from a fresh pointer
        do_reset();
        op0 = 1'b0; a0 = 64'h10; b0 = 64'h20; p0 = 64'h25;
        op1 = 1'b0; a1 = 64'h0001_0000_0000_0000; b1 = 64'h0000_FFFF_FFFF_FFFF;
        p1 = 64'h0002_0000_0000_0000;
        req0 = 1'b1; req1 = 1'b1;
        grant_wait(0, 10); req0 = 1'b1;
        wait_done(100, n);
        chk("t2_id_a", rsp_id, 1'b0);
        chk("t2_res_a", res, 64'hB);
        chk("t2_flag_a", res_flag, 1'b1);
        grant_wait(1, 10); req1 = 1'b1;
        wait_done(100, n);
        chk("t2_id_b", rsp_id, 1'b1);
        chk("t2_res_b", res, 64'h0001_FFFF_FFFF_FFFF);
        grant_wait(0, 10);
        wait_done(100, n);
        chk("t2_id_c", rsp_id, 1'b0);
        grant_wait(1, 10);
        wait_done(100, n);
        chk("t2_id_d", rsp_id, 1'b1);
        step();

        // 3: modular subtract with borrow -> corrected register
        s_madd = n_madd; s_msub = n_msub; s_o0 = n_o0; s_o1 = n_o1;
        op1 = 1'b1; a1 = 64'h5; b1 = 64'h9; p1 = 64'h11;
        req1 = 1'b1;
        grant_wait(1, 10);
        wait_done(100, n);
        chk("t3_res", res, 64'hD);
        chk("t3_flag", res_flag, 1'b1);
        chk("t3_outs1", n_o1 - s_o1, 4);
        chk("t3_outs0", n_o0 - s_o0, 0);
        chk("t3_msub", n_msub - s_msub, 1);
        chk("t3_madd", n_madd - s_madd, 0);
        step();

        // 4: reset during LDB, pending req1 wins after release
        op0 = 1'b0; a0 = 64'h7; b0 = 64'h8; p0 = 64'h100;
        req0 = 1'b1;
        grant_wait(0, 10);
        repeat (5) step();
        req1 = 1'b1;
        rst = 1'b0;
        #1;
        chk("t4_gnt1", gnt1, 1'b0);
        chk("t4_loadb", loadb, 1'b0);
        chk("t4_datain", datain, 16'h0);
        step();
        step();
        rst = 1'b1;
        grant_wait(1, 10);
        req0 = 1'b1;
        wait_done(100, n);
        chk("t4_id1", rsp_id, 1'b1);
        grant_wait(0, 10);
        wait_done(100, n);
        chk("t4_id0", rsp_id, 1'b0);
        chk("t4_res0", res, 64'hF);
        step();

        // 6: request arriving during WAIT is held off until the IDLE cycle after done
        req0 = 1'b1;
        grant_wait(0, 10);
        repeat (13) step();
        req1 = 1'b1;
        s_g1 = n_g1;
        wait_done(100, n);
        step();
        #1;
        chk("t6_no_early_gnt1", n_g1 - s_g1, 0);
        chk("t6_gnt1_idle", gnt1, 1'b1);
        grant_wait(1, 10);
        wait_done(100, n);
        step();

        // 5: unit never answers
        u_mute = 1'b1;
        req0 = 1'b1;
        grant_wait(0, 10);
`ifdef MADD_SCHED_TIMEOUT_EN
        wait_done(100, n);
        chk("t5_latency", n, 3 * NW + 1 + TMO);
        chk("t5_err", err, 1'b1);
        chk("t5_res", res, 64'h0);
        step();
`else
        s_done = n_done;
        repeat (1000) step();
        chk("t5_no_done", n_done - s_done, 0);
        chk("t5_err", err, 1'b0);
`endif
        u_mute = 1'b0;
        do_reset();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
